// File: rtl/lut_sched_pkg.sv
// Purpose: shared types and constants for the LUT neuron scheduler and its table RAM.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package lut_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int FANIN_DEFAULT = 8;

  // Width of a neuron index; a single-neuron layer still needs a 1-bit select.
  function automatic int neuron_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lut_table_ram.sv
// Purpose: NEURONS x 2^FANIN bit truth-table store; sync write, comb read, optional readback (LUT_SCHED_CFG_READBACK_EN).
// Latency: lookup is combinational; a write is visible from the next cycle; readback data registers one cycle after cfg_re.
// Backpressure: none here; the caller gates we/re with its own ready.
module lut_table_ram
  import lut_sched_pkg::*;
#(
  parameter int NEURONS = 16,
  parameter int FANIN   = FANIN_DEFAULT
) (
  input  logic                          clk,
`ifdef LUT_SCHED_CFG_READBACK_EN
  input  logic                          rst_n,
  input  logic                          re,
  output logic                          cfg_rdata,
`endif
  input  logic                          we,
  input  logic [neuron_w(NEURONS)-1:0]  cfg_neuron,
  input  logic [FANIN-1:0]              cfg_addr,
  input  logic                          cfg_bit,
  input  logic [neuron_w(NEURONS)-1:0]  rd_neuron,
  input  logic [FANIN-1:0]              rd_addr,
  output logic                          rd_bit
);

  localparam int NW    = neuron_w(NEURONS);
  localparam int DEPTH = 2 ** FANIN;
  localparam logic [NW:0] NLIM = (NW + 1)'(NEURONS);

  // Table contents are deliberately never reset so they survive a reset of the scheduler.
  logic [DEPTH-1:0] mem [NEURONS];
  logic             cfg_hit;

  // Out-of-range neuron selects (non power-of-two layers) must not touch storage.
  assign cfg_hit = ({1'b0, cfg_neuron} < NLIM);

  // Single write port driven from the configuration interface.
  always_ff @(posedge clk) begin
    if (we && cfg_hit) begin
      mem[cfg_neuron][cfg_addr] <= cfg_bit;
    end
  end

  assign rd_bit = mem[rd_neuron][rd_addr];

`ifdef LUT_SCHED_CFG_READBACK_EN
  // Readback samples the pre-write contents, so a same-cycle write returns the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_rdata <= 1'b0;
    end else if (re) begin
      cfg_rdata <= cfg_hit ? mem[cfg_neuron][cfg_addr] : 1'b0;
    end
  end
`endif

endmodule

// File: rtl/lut_neuron_scheduler.sv
// Purpose: time-multiplexed evaluator for NEURONS runtime-loadable LUT neurons (optional readback: LUT_SCHED_CFG_READBACK_EN).
// Latency: beat accepted in cycle T gives out_valid in cycle T+NEURONS+1; one result per NEURONS+2 cycles.
// Backpressure: result held in DONE until out_ready; input and config are refused (ready low) outside IDLE.
module lut_neuron_scheduler
  import lut_sched_pkg::*;
#(
  parameter int NEURONS = 16,
  parameter int FANIN   = FANIN_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NEURONS*FANIN-1:0]      in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NEURONS-1:0]            out_data,
  input  logic                          cfg_we,
  output logic                          cfg_ready,
  input  logic [neuron_w(NEURONS)-1:0]  cfg_neuron,
  input  logic [FANIN-1:0]              cfg_addr,
`ifdef LUT_SCHED_CFG_READBACK_EN
  input  logic                          cfg_re,
  output logic                          cfg_rdata,
`endif
  input  logic                          cfg_bit
);

  localparam int NW = neuron_w(NEURONS);
  localparam logic [NW-1:0] LAST_IDX = NW'(NEURONS - 1);

  state_t                     state;
  state_t                     state_nxt;
  logic [NEURONS*FANIN-1:0]   operand;
  logic [NW-1:0]              idx;
  logic [FANIN-1:0]           words [NEURONS];
  logic                       rd_bit;

  for (genvar g = 0; g < NEURONS; g++) begin : g_unpack
    assign words[g] = operand[g*FANIN +: FANIN];
  end

  lut_table_ram #(
    .NEURONS (NEURONS),
    .FANIN   (FANIN)
  ) u_table (
    .clk        (clk),
`ifdef LUT_SCHED_CFG_READBACK_EN
    .rst_n      (rst_n),
    .re         (cfg_re & cfg_ready),
    .cfg_rdata  (cfg_rdata),
`endif
    .we         (cfg_we & cfg_ready),
    .cfg_neuron (cfg_neuron),
    .cfg_addr   (cfg_addr),
    .cfg_bit    (cfg_bit),
    .rd_neuron  (idx),
    .rd_addr    (words[idx]),
    .rd_bit     (rd_bit)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: accept in IDLE, sweep all neurons in RUN, hold result in DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)        state_nxt = RUN;
      RUN:     if (idx == LAST_IDX) state_nxt = DONE;
      DONE:    if (out_ready)       state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded purely from the registered state.
  always_comb begin
    in_ready  = 1'b0;
    cfg_ready = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    begin in_ready = 1'b1; cfg_ready = 1'b1; end
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: capture the operand on accept, then write one neuron result per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      operand  <= '0;
      idx      <= '0;
      out_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            operand <= in_data;
            idx     <= '0;
          end
        end
        RUN: begin
          out_data[idx] <= rd_bit;
          idx           <= (idx == LAST_IDX) ? '0 : idx + NW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lut_neuron_scheduler.sv
// Purpose: self-checking bench for lut_neuron_scheduler (NEURONS=16, FANIN=8), optional readback via LUT_SCHED_CFG_READBACK_EN.
// Latency: transaction model expects out_valid 17 cycles after acceptance.
// Backpressure: bench holds out_ready low by default and pulses it to release each result.
module tb_lut_neuron_scheduler;

  localparam int N = 16;
  localparam int F = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [N*F-1:0] in_data;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   out_data;
  logic           cfg_we;
  logic           cfg_ready;
  logic [3:0]     cfg_neuron;
  logic [F-1:0]   cfg_addr;
  logic           cfg_bit;
`ifdef LUT_SCHED_CFG_READBACK_EN
  logic           cfg_re;
  logic           cfg_rdata;
`endif

  lut_neuron_scheduler #(.NEURONS(N), .FANIN(F)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .cfg_we     (cfg_we),
    .cfg_ready  (cfg_ready),
    .cfg_neuron (cfg_neuron),
    .cfg_addr   (cfg_addr),
`ifdef LUT_SCHED_CFG_READBACK_EN
    .cfg_re     (cfg_re),
    .cfg_rdata  (cfg_rdata),
`endif
    .cfg_bit    (cfg_bit)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  bit [255:0]   mtab [N];
  bit           mbusy = 1'b0;
  int           macc  = 0;
  int           cyc   = 0;
  logic [N-1:0] mres  = '0;
  logic [N-1:0] mlast = '0;

  function automatic logic [N-1:0] eval(input logic [N*F-1:0] d);
    logic [N-1:0] r;
    logic [F-1:0] w;
    for (int i = 0; i < N; i++) begin
      w    = d[i*F +: F];
      r[i] = mtab[i][w];
    end
    return r;
  endfunction

  // Compare every cycle on the falling edge, then advance the model for the coming rising edge.
  always @(negedge clk) begin
    bit exp_v;
    if (!rst_n) begin
      mbusy = 1'b0;
      mlast = '0;
    end
    exp_v = mbusy && (cyc >= macc + N + 1);
    check("m_in_ready", {31'b0, in_ready}, {31'b0, !mbusy});
    check("m_cfg_ready", {31'b0, cfg_ready}, {31'b0, !mbusy});
    check("m_out_valid", {31'b0, out_valid}, {31'b0, exp_v});
    if (exp_v)
      check("m_out_data_done", {16'b0, out_data}, {16'b0, mres});
    else if (!mbusy)
      check("m_out_data_hold", {16'b0, out_data}, {16'b0, mlast});
    if (rst_n) begin
      if (!mbusy) begin
        if (cfg_we) mtab[cfg_neuron][cfg_addr] = cfg_bit;
        if (in_valid) begin
          mbusy = 1'b1;
          macc  = cyc;
          mres  = eval(in_data);
        end
      end else if (exp_v && out_ready) begin
        mbusy = 1'b0;
        mlast = mres;
      end
    end
    cyc++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int n, input int a, input logic b);
    cfg_we     = 1'b1;
    cfg_neuron = n[3:0];
    cfg_addr   = a[F-1:0];
    cfg_bit    = b;
    step();
    cfg_we     = 1'b0;
  endtask

  task automatic send(input logic [N*F-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    if (!out_valid) check("wait_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  logic [N*F-1:0] all01;
  logic [N-1:0]   hold;
  int             n;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

  initial begin
    all01      = {N{8'h01}};
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    cfg_we     = 1'b0;
    cfg_neuron = '0;
    cfg_addr   = '0;
    cfg_bit    = 1'b0;
`ifdef LUT_SCHED_CFG_READBACK_EN
    cfg_re     = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data", {16'b0, out_data}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_cfg_ready", {31'b0, cfg_ready}, 32'd1);
    rst_n = 1'b1;
    step();

    // Neuron i: table[a] = a[0] ^ (i & 1).
    for (int i = 0; i < N; i++) begin
      for (int a = 0; a < 256; a++) begin
        cfg_we     = 1'b1;
        cfg_neuron = i[3:0];
        cfg_addr   = a[F-1:0];
        cfg_bit    = a[0] ^ i[0];
        step();
      end
    end
    cfg_we = 1'b0;

    // Base evaluation and latency.
    send(all01);
    wait_done(n);
    check("latency", n + 1, 32'd17);
    check("result_base", {16'b0, out_data}, 32'h5555);

    // Backpressure in DONE.
    hold = out_data;
    repeat (10) begin
      step();
      check("bp_valid", {31'b0, out_valid}, 32'd1);
      check("bp_data", {16'b0, out_data}, {16'b0, hold});
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    release_result();
    check("release_idle", {31'b0, in_ready}, 32'd1);

    // Config write while busy is dropped.
    send(all01);
    step();
    step();
    cfg_write(3, 1, 1'b1);
    wait_done(n);
    check("busy_write_dropped", {16'b0, out_data}, 32'h5555);
    release_result();

    // Same write in IDLE flips bit 3.
    cfg_write(3, 1, 1'b1);
    send(all01);
    wait_done(n);
    check("idle_write", {16'b0, out_data}, 32'h555D);
    release_result();

    // Simultaneous write and accept: the new entry value is used.
    cfg_we     = 1'b1;
    cfg_neuron = 4'd3;
    cfg_addr   = 8'h01;
    cfg_bit    = 1'b0;
    in_valid   = 1'b1;
    in_data    = all01;
    step();
    cfg_we     = 1'b0;
    in_valid   = 1'b0;
    wait_done(n);
    check("simul_write_accept", {16'b0, out_data}, 32'h5555);
    release_result();

    // Reset mid-RUN aborts; tables survive.
    send(all01);
    repeat (5) step();
    rst_n = 1'b0;
    step();
    check("midrun_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrun_rst_out_data", {16'b0, out_data}, 32'd0);
    check("midrun_rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("midrun_rst_cfg_ready", {31'b0, cfg_ready}, 32'd1);
    rst_n = 1'b1;
    step();
    send(all01);
    wait_done(n);
    check("after_rst_result", {16'b0, out_data}, 32'h5555);
    release_result();

`ifdef LUT_SCHED_CFG_READBACK_EN
    cfg_write(15, 255, 1'b1);
    cfg_re     = 1'b1;
    cfg_neuron = 4'd15;
    cfg_addr   = 8'hFF;
    step();
    cfg_re     = 1'b0;
    check("rb_idle", {31'b0, cfg_rdata}, 32'd1);
    send(all01);
    step();
    step();
    cfg_re     = 1'b1;
    cfg_neuron = 4'd0;
    cfg_addr   = 8'h00;
    step();
    cfg_re     = 1'b0;
    check("rb_during_run", {31'b0, cfg_rdata}, 32'd1);
    wait_done(n);
    release_result();
    cfg_re = 1'b1;
    step();
    cfg_re = 1'b0;
    check("rb_zero_entry", {31'b0, cfg_rdata}, 32'd0);
`endif

    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
